// File: rtl/stage_4_mem_pkg.sv
// Shared encodings and lane helpers for the memory-access pipeline stage.
package stage_4_mem_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  function automatic logic [31:0] sign_extend8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sign_extend16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Legal func_3 for the direction and naturally aligned for its width.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = (lo[0] == 1'b0);
      F3_LW:   ok = (lo == 2'b00);
      F3_LBU:  ok = !is_store;
      F3_LHU:  ok = !is_store && (lo[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stage_4_mem_load_align.sv
// Extracts and extends the addressed byte/half/word from a memory read word.
module mem_load_align
  import stage_4_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func_3_i,
  output logic [31:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (func_3_i)
      F3_LB:   load_o = sign_extend8(byte_v);
      F3_LBU:  load_o = {24'h000000, byte_v};
      F3_LH:   load_o = sign_extend16(half_v);
      F3_LHU:  load_o = {16'h0000, half_v};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_4_mem.sv
// Memory-access stage: ALU results pass through, loads/stores run a req/ack
// transaction with timeout; one writeback record per accepted op.
module stage_4_mem
  import stage_4_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        o_valid,
  output logic [4:0]  o_rd_num,
  output logic [31:0] o_wb_data,
  output logic        o_wb_en,
  output logic        o_misalign,
  output logic        o_bus_err
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q;
  logic [2:0]       func_3_q;
  logic             ld_wb_en_q;

  logic        is_store, ok, alu_wb_en;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_val;

  mem_load_align u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_lo_q),
    .func_3_i  (func_3_q),
    .load_o    (load_val)
  );

  always_comb begin
    is_store  = (i_opcode == OPC_STORE);
    ok        = access_ok(is_store, i_func_3, i_alu_out[1:0]);
    alu_wb_en = (i_opcode != OPC_STORE) && (i_opcode != OPC_BRANCH) && (i_rd_num != 5'd0);
    cnt_d     = cnt_q + 1'b1;
    case (i_func_3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << i_alu_out[1:0];
        wdata_d = {4{i_rs_2[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << i_alu_out[1:0];
        wdata_d = {2{i_rs_2[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wdata_d = i_rs_2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= '0;
      func_3_q   <= '0;
      ld_wb_en_q <= 1'b0;
      o_ready    <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      o_valid    <= 1'b0;
      o_rd_num   <= '0;
      o_wb_data  <= '0;
      o_wb_en    <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            o_rd_num <= i_rd_num;
            if (!i_op_type) begin
              o_valid   <= 1'b1;
              o_wb_data <= i_alu_out;
              o_wb_en   <= alu_wb_en;
            end else if (!ok) begin
              o_valid    <= 1'b1;
              o_misalign <= 1'b1;
              o_wb_data  <= '0;
              o_wb_en    <= 1'b0;
            end else begin
              state_q    <= ST_REQ;
              o_ready    <= 1'b0;
              mem_req    <= 1'b1;
              mem_we     <= is_store;
              mem_addr   <= {i_alu_out[31:2], 2'b00};
              mem_wdata  <= wdata_d;
              mem_be     <= be_d;
              cnt_q      <= '0;
              addr_lo_q  <= i_alu_out[1:0];
              func_3_q   <= i_func_3;
              ld_wb_en_q <= !is_store && (i_rd_num != 5'd0);
            end
          end
        end
        ST_REQ: begin
          // An ack in the final timeout cycle still completes the access.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            state_q   <= ST_RESP;
            o_valid   <= 1'b1;
            o_wb_en   <= ld_wb_en_q;
            o_wb_data <= mem_we ? '0 : load_val;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            mem_req   <= 1'b0;
            state_q   <= ST_RESP;
            o_valid   <= 1'b1;
            o_bus_err <= 1'b1;
            o_wb_en   <= 1'b0;
            o_wb_data <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
